writeback_arbiter: RTL and testbench



---
 rtl/writeback_arbiter.sv | 136 +++++++++++++
 tb/tb_writeback_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers one ALU and one LSU result, round-robins the single
// register-file write port, drops x0 writes and tracks pending destinations.
module writeback_arbiter #(
  parameter int NRegs        = 32,
  parameter int RegWidth     = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iAluValid,
  output logic                    oAluReady,
  input  logic [RegAddrWidth-1:0] iAluRd,
  input  logic [RegWidth-1:0]     iAluData,
  input  logic                    iLsuValid,
  output logic                    oLsuReady,
  input  logic [RegAddrWidth-1:0] iLsuRd,
  input  logic [RegWidth-1:0]     iLsuData,
  input  logic                    iIssueEn,
  input  logic [RegAddrWidth-1:0] iIssueRd,
  output logic                    oWriteEn,
  output logic [RegAddrWidth-1:0] oAddr_Rd,
  output logic [RegWidth-1:0]     oRd,
  output logic [NRegs-1:0]        oBusy
);

  logic                    alu_v_q, alu_v_d;
  logic [RegAddrWidth-1:0] alu_rd_q, alu_rd_d;
  logic [RegWidth-1:0]     alu_data_q, alu_data_d;
  logic                    lsu_v_q, lsu_v_d;
  logic [RegAddrWidth-1:0] lsu_rd_q, lsu_rd_d;
  logic [RegWidth-1:0]     lsu_data_q, lsu_data_d;
  // 1 = LSU was granted most recently, so ALU wins the next contention
  logic                    last_lsu_q, last_lsu_d;
  logic [NRegs-1:0]        busy_q, busy_d;

  logic grant_alu_s, grant_lsu_s;
  logic alu_acc_s, lsu_acc_s;

  // Round-robin grant and ready generation
  always_comb begin
    grant_alu_s = alu_v_q & (~lsu_v_q | last_lsu_q);
    grant_lsu_s = lsu_v_q & (~alu_v_q | ~last_lsu_q);
    oAluReady   = ~alu_v_q | grant_alu_s;
    oLsuReady   = ~lsu_v_q | grant_lsu_s;
    alu_acc_s   = iAluValid & oAluReady;
    lsu_acc_s   = iLsuValid & oLsuReady;
  end

  // Register-file write port, driven straight from the holding entries
  always_comb begin
    oWriteEn = grant_alu_s | grant_lsu_s;
    oAddr_Rd = {RegAddrWidth{1'b0}};
    oRd      = {RegWidth{1'b0}};
    if (grant_alu_s) begin
      oAddr_Rd = alu_rd_q;
      oRd      = alu_data_q;
    end else if (grant_lsu_s) begin
      oAddr_Rd = lsu_rd_q;
      oRd      = lsu_data_q;
    end else begin
      oAddr_Rd = {RegAddrWidth{1'b0}};
      oRd      = {RegWidth{1'b0}};
    end
  end

  // Holding entries: a same-edge accept overrides the drain; x0 results are discarded
  always_comb begin
    alu_v_d    = alu_v_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    lsu_v_d    = lsu_v_q;
    lsu_rd_d   = lsu_rd_q;
    lsu_data_d = lsu_data_q;
    last_lsu_d = last_lsu_q;
    if (alu_acc_s) begin
      alu_v_d    = (iAluRd != {RegAddrWidth{1'b0}});
      alu_rd_d   = iAluRd;
      alu_data_d = iAluData;
    end else if (grant_alu_s) begin
      alu_v_d = 1'b0;
    end else begin
      alu_v_d = alu_v_q;
    end
    if (lsu_acc_s) begin
      lsu_v_d    = (iLsuRd != {RegAddrWidth{1'b0}});
      lsu_rd_d   = iLsuRd;
      lsu_data_d = iLsuData;
    end else if (grant_lsu_s) begin
      lsu_v_d = 1'b0;
    end else begin
      lsu_v_d = lsu_v_q;
    end
    if (grant_alu_s) begin
      last_lsu_d = 1'b0;
    end else if (grant_lsu_s) begin
      last_lsu_d = 1'b1;
    end else begin
      last_lsu_d = last_lsu_q;
    end
  end

  // Busy scoreboard: a new issue to r beats the completing write to r
  always_comb begin
    busy_d = {NRegs{1'b0}};
    for (int r = 1; r < NRegs; r++) begin
      busy_d[r] = (iIssueEn & (iIssueRd == RegAddrWidth'(r))) |
                  (busy_q[r] & ~(oWriteEn & (oAddr_Rd == RegAddrWidth'(r))));
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      alu_v_q    <= 1'b0;
      alu_rd_q   <= {RegAddrWidth{1'b0}};
      alu_data_q <= {RegWidth{1'b0}};
      lsu_v_q    <= 1'b0;
      lsu_rd_q   <= {RegAddrWidth{1'b0}};
      lsu_data_q <= {RegWidth{1'b0}};
      last_lsu_q <= 1'b1;
      busy_q     <= {NRegs{1'b0}};
    end else begin
      alu_v_q    <= alu_v_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      lsu_v_q    <= lsu_v_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
      last_lsu_q <= last_lsu_d;
      busy_q     <= busy_d;
    end
  end

  assign oBusy = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; register-file writes are checked in order
// against a scoreboard queue filled as results are driven.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iAluValid, oAluReady;
  logic [4:0]  iAluRd;
  logic [31:0] iAluData;
  logic        iLsuValid, oLsuReady;
  logic [4:0]  iLsuRd;
  logic [31:0] iLsuData;
  logic        iIssueEn;
  logic [4:0]  iIssueRd;
  logic        oWriteEn;
  logic [4:0]  oAddr_Rd;
  logic [31:0] oRd;
  logic [31:0] oBusy;

  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;
  wr_t exp_q[$];

  writeback_arbiter #(.NRegs(32), .RegWidth(32), .RegAddrWidth(5)) dut (
    .iClk(iClk), .iRst(iRst),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluRd(iAluRd), .iAluData(iAluData),
    .iLsuValid(iLsuValid), .oLsuReady(oLsuReady), .iLsuRd(iLsuRd), .iLsuData(iLsuData),
    .iIssueEn(iIssueEn), .iIssueRd(iIssueRd),
    .oWriteEn(oWriteEn), .oAddr_Rd(oAddr_Rd), .oRd(oRd), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Scoreboard: every write seen on the port must be the oldest expected one
  always @(negedge iClk) begin
    if (mon_en && oWriteEn) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(oAddr_Rd), 32'(e.rd));
        chk("wr_data", oRd, e.data);
      end
    end
  end

  initial begin
    int  ka, kl, c;
    logic acc_a, acc_l, exp_ra, exp_rl;
    wr_t w;

    iRst = 1'b1; iIssueEn = 1'b0; iIssueRd = 5'd0;
    iAluValid = 1'b1; iAluRd = 5'd9;  iAluData = 32'h9999_0000;
    iLsuValid = 1'b1; iLsuRd = 5'd10; iLsuData = 32'h1010_0000;

    // Reset held two edges with both sources valid
    tick();
    @(negedge iClk);
    chk("rst_wen", 32'(oWriteEn), 32'd0);
    chk("rst_busy", oBusy, 32'd0);
    chk("rst_addr", 32'(oAddr_Rd), 32'd0);
    chk("rst_data", oRd, 32'd0);
    tick();
    iRst = 1'b0; iAluValid = 1'b0; iLsuValid = 1'b0;
    iIssueEn = 1'b1; iIssueRd = 5'd5;
    mon_en = 1'b1;
    @(negedge iClk);
    chk("post_rst_alu_rdy", 32'(oAluReady), 32'd1);
    chk("post_rst_lsu_rdy", 32'(oLsuReady), 32'd1);
    chk("post_rst_wen", 32'(oWriteEn), 32'd0);
    chk("post_rst_busy", oBusy, 32'd0);

    // Single ALU write to x5
    tick();
    iIssueEn = 1'b0;
    iAluValid = 1'b1; iAluRd = 5'd5; iAluData = 32'hDEAD_BEEF;
    w.rd = 5'd5; w.data = 32'hDEAD_BEEF; exp_q.push_back(w);
    @(negedge iClk);
    chk("single_busy_set", oBusy, 32'h0000_0020);
    chk("single_alu_rdy", 32'(oAluReady), 32'd1);
    tick();
    iAluValid = 1'b0;
    @(negedge iClk);
    chk("single_wen", 32'(oWriteEn), 32'd1);
    chk("single_busy_hold", oBusy, 32'h0000_0020);
    tick();
    @(negedge iClk);
    chk("single_busy_clr", oBusy, 32'd0);
    chk("single_wen_off", 32'(oWriteEn), 32'd0);

    // Single LSU write so that ALU wins the next contention
    tick();
    iLsuValid = 1'b1; iLsuRd = 5'd4; iLsuData = 32'h0000_0044;
    w.rd = 5'd4; w.data = 32'h0000_0044; exp_q.push_back(w);
    tick();
    iLsuValid = 1'b0;
    @(negedge iClk);
    tick();

    // Contention: both sources stream 4 results; writes alternate ALU/LSU
    for (int k = 0; k < 4; k++) begin
      w.rd = 5'd1; w.data = 32'hA000_0000 + 32'(k); exp_q.push_back(w);
      w.rd = 5'd2; w.data = 32'hB000_0000 + 32'(k); exp_q.push_back(w);
    end
    ka = 0; kl = 0; c = 0;
    while ((ka < 4 || kl < 4) && c < 40) begin
      iAluValid = (ka < 4); iAluRd = 5'd1; iAluData = 32'hA000_0000 + 32'(ka);
      iLsuValid = (kl < 4); iLsuRd = 5'd2; iLsuData = 32'hB000_0000 + 32'(kl);
      @(negedge iClk);
      if (ka < 4 && kl < 4) begin
        exp_ra = (c == 0) ? 1'b1 : (c % 2 == 1);
        exp_rl = (c == 0) ? 1'b1 : (c % 2 == 0);
        chk("cont_alu_rdy", 32'(oAluReady), 32'(exp_ra));
        chk("cont_lsu_rdy", 32'(oLsuReady), 32'(exp_rl));
      end
      acc_a = iAluValid & oAluReady;
      acc_l = iLsuValid & oLsuReady;
      tick();
      ka += int'(acc_a);
      kl += int'(acc_l);
      c++;
    end
    chk("cont_budget", 32'(c < 40), 32'd1);
    iAluValid = 1'b0; iLsuValid = 1'b0;
    repeat (4) tick();
    @(negedge iClk);
    chk("cont_drained", 32'(exp_q.size()), 32'd0);
    chk("cont_wen_off", 32'(oWriteEn), 32'd0);

    // x0 result is accepted but never written
    tick();
    iLsuValid = 1'b1; iLsuRd = 5'd0; iLsuData = 32'h0000_1234;
    @(negedge iClk);
    chk("x0_lsu_rdy", 32'(oLsuReady), 32'd1);
    tick();
    iLsuValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge iClk);
      chk("x0_wen", 32'(oWriteEn), 32'd0);
      chk("x0_busy", oBusy, 32'd0);
      tick();
    end

    // Write to x7 completes while a newer x7 producer issues: busy stays set
    iIssueEn = 1'b1; iIssueRd = 5'd7;
    tick();
    iIssueEn = 1'b0;
    iAluValid = 1'b1; iAluRd = 5'd7; iAluData = 32'h0000_0077;
    w.rd = 5'd7; w.data = 32'h0000_0077; exp_q.push_back(w);
    @(negedge iClk);
    chk("coll_busy_pre", oBusy, 32'h0000_0080);
    tick();
    iAluValid = 1'b0;
    iIssueEn = 1'b1; iIssueRd = 5'd7;
    @(negedge iClk);
    chk("coll_wen", 32'(oWriteEn), 32'd1);
    tick();
    iIssueEn = 1'b0;
    @(negedge iClk);
    chk("coll_busy_post", oBusy, 32'h0000_0080);
    iAluValid = 1'b1; iAluRd = 5'd7; iAluData = 32'h0000_0078;
    w.rd = 5'd7; w.data = 32'h0000_0078; exp_q.push_back(w);
    tick();
    iAluValid = 1'b0;
    @(negedge iClk);
    tick();
    @(negedge iClk);
    chk("coll_busy_clr", oBusy, 32'd0);

    // LSU write leaves last grant = LSU, then reset mid-operation
    iLsuValid = 1'b1; iLsuRd = 5'd8; iLsuData = 32'h0000_0088;
    w.rd = 5'd8; w.data = 32'h0000_0088; exp_q.push_back(w);
    tick();
    iLsuValid = 1'b0;
    @(negedge iClk);
    tick();
    iIssueEn = 1'b1; iIssueRd = 5'd3;
    tick();
    iIssueRd = 5'd6;
    tick();
    iIssueEn = 1'b0;
    iAluValid = 1'b1; iAluRd = 5'd3; iAluData = 32'h0000_0033;
    iLsuValid = 1'b1; iLsuRd = 5'd6; iLsuData = 32'h0000_0066;
    @(negedge iClk);
    chk("rmid_busy_pre", oBusy, 32'h0000_0048);
    tick();
    iAluValid = 1'b0; iLsuValid = 1'b0;
    iRst = 1'b1; mon_en = 1'b0;
    @(negedge iClk);
    chk("rmid_full_wen", 32'(oWriteEn), 32'd1);
    chk("rmid_full_addr", 32'(oAddr_Rd), 32'd3);
    tick();
    iRst = 1'b0; mon_en = 1'b1;
    @(negedge iClk);
    chk("rmid_wen", 32'(oWriteEn), 32'd0);
    chk("rmid_busy", oBusy, 32'd0);
    chk("rmid_alu_rdy", 32'(oAluReady), 32'd1);
    chk("rmid_lsu_rdy", 32'(oLsuReady), 32'd1);
    tick();
    @(negedge iClk);
    chk("rmid_wen2", 32'(oWriteEn), 32'd0);

    // After reset, first contention grants ALU
    iAluValid = 1'b1; iAluRd = 5'd11; iAluData = 32'h0000_000A;
    iLsuValid = 1'b1; iLsuRd = 5'd12; iLsuData = 32'h0000_000B;
    w.rd = 5'd11; w.data = 32'h0000_000A; exp_q.push_back(w);
    w.rd = 5'd12; w.data = 32'h0000_000B; exp_q.push_back(w);
    tick();
    iAluValid = 1'b0; iLsuValid = 1'b0;
    @(negedge iClk);
    chk("rr_first_addr", 32'(oAddr_Rd), 32'd11);
    tick();
    @(negedge iClk);
    tick();
    @(negedge iClk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_wen", 32'(oWriteEn), 32'd0);
    chk("final_busy", oBusy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
